// File: rtl/alu_pkg.sv
// Shared ALU op codes, FSM state encoding and defaults for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned XLEN_DFLT = 32;
  localparam int unsigned SHW_DFLT  = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } shift_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

  function automatic shift_e to_shift(input logic [3:0] ctrl);
    case (ctrl)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU datapath; shift codes and undefined codes yield zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DFLT
) (
  input  logic [3:0]      ctrl_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative 1-bit-per-cycle
// shifter, registered result over a valid/ready handshake with flush.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DFLT,
  parameter int unsigned SHW  = SHW_DFLT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e          state_q, state_d;
  shift_e          shk_q, shk_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic [XLEN-1:0] core_y;
  logic [XLEN-1:0] acc_sh;
  logic [SHW-1:0]  shamt;

  assign shamt = op_b[SHW-1:0];

  alu_core #(.XLEN(XLEN)) u_core (
    .ctrl_i (alu_ctrl),
    .a_i    (op_a),
    .b_i    (op_b),
    .y_o    (core_y)
  );

  always_comb begin
    acc_sh = acc_q;
    case (shk_q)
      SH_SLL:  acc_sh = {acc_q[XLEN-2:0], 1'b0};
      SH_SRL:  acc_sh = {1'b0, acc_q[XLEN-1:1]};
      SH_SRA:  acc_sh = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: acc_sh = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shk_d    = shk_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;

    // Flush wins over accept, shift completion and the output handshake.
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_shift(alu_ctrl)) begin
              result_d = core_y;
              zero_d   = (core_y == '0);
              state_d  = ST_DONE;
            end else if (shamt == '0) begin
              result_d = op_a;
              zero_d   = (op_a == '0);
              state_d  = ST_DONE;
            end else begin
              acc_d   = op_a;
              cnt_d   = shamt;
              shk_d   = to_shift(alu_ctrl);
              state_d = ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          acc_d = acc_sh;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_d = acc_sh;
            zero_d   = (acc_sh == '0);
            state_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shk_q    <= SH_SLL;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shk_q    <= shk_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec with hand-computed expected results and latencies.
module tb_alu_seq_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.XLEN(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present one op, then count edges after the accept edge until out_valid.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat,
                       input logic [31:0] exp_res, input logic exp_zero);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; out_ready = 1'b0;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
  endtask

  task automatic release_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;

    // Reset: inputs ignored, outputs at reset values
    in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'h1; op_b = 32'h1;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_wrap", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 1'b0);
    release_op("add_wrap");
    do_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 0, 32'h0, 1'b1);
    release_op("sub_zero");
    do_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 1'b0);
    release_op("slt_neg");
    do_op("slt_swap", ALU_SLT, 32'h1, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
    release_op("slt_swap");
    do_op("and", ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 32'h0F00_0F00, 1'b0);
    release_op("and");
    do_op("or", ALU_OR, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 32'hFFF0_FFF0, 1'b0);
    release_op("or");

    do_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF, 1'b0);
    release_op("sra31");
    do_op("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 31, 32'h0000_0001, 1'b0);
    release_op("srl31");
    do_op("sll_amt0", ALU_SLL, 32'h1, 32'h20, 0, 32'h1, 1'b0);
    release_op("sll_amt0");
    do_op("sll_hi_ign", ALU_SLL, 32'h1, 32'hFFFF_FFE3, 3, 32'h8, 1'b0);
    release_op("sll_hi_ign");
    do_op("srl_to0", ALU_SRL, 32'h1, 32'd1, 1, 32'h0, 1'b1);
    release_op("srl_to0");

    // Backpressure in DONE, then a new op held across the DONE->IDLE edge
    do_op("bp", ALU_ADD, 32'd10, 32'd20, 0, 32'd30, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", result, 32'd30);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'd100; op_b = 32'd1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_no_accept_ov", {31'b0, out_valid}, 32'd0);
    check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_ov", {31'b0, out_valid}, 32'd1);
    check("bp_next_res", result, 32'd101);
    release_op("bp_next");

    // Flush during a 10-cycle SLL
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = ALU_SLL; op_a = 32'h3; op_b = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ov", {31'b0, out_valid}, 32'd0);
    check("flush_idle", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("flush_never_valid", seen, 0);
    do_op("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 0, 32'h0F0F_0F0F, 1'b0);
    release_op("xor");

    // Asynchronous reset in the middle of a shift
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = ALU_SRL; op_a = 32'hFFFF_FFFF; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_zero", {31'b0, zero}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("arst_no_output", seen, 0);

    do_op("undef", 4'hF, 32'h1234_5678, 32'h1, 0, 32'h0, 1'b1);
    release_op("undef");
    do_op("undef9", 4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
    release_op("undef9");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
